// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: hazard FSM states, register constants
// and the load-use match helper.
package riscv_pipe_pkg;

  localparam int XLEN = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } hcu_state_e;

  function automatic logic load_use(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       use_rs1,
    input logic       use_rs2
  );
    return mem_read && (rd != REG_ZERO) &&
           ((use_rs1 && (rs1 == rd)) ||
            (use_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter for pipeline performance statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall / bubble / flush / freeze generation for hazards that the
// EX forwarding path cannot cover, plus wait timeout and counters.
module hazard_control_unit
  import riscv_pipe_pkg::*;
#(
  parameter int LOAD_USE_STALL = 1,
  parameter int WAIT_TIMEOUT   = 255,
  parameter int CNT_W          = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_use_rs1,
  input  logic             if_id_use_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_freeze,
  output logic             bus_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int REM_W = 3;
  localparam int TMR_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [REM_W-1:0] LU_EXTRA = REM_W'(LOAD_USE_STALL - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(WAIT_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  hcu_state_e       state_q;
  hcu_state_e       state_n;
  logic [REM_W-1:0] rem_q;
  logic [REM_W-1:0] rem_n;
  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_n;
  logic             err_q;
  logic             err_n;

  logic lu;
  logic mem_stall;
  logic run_flow;
  logic pc_write_c;
  logic if_id_write_c;
  logic if_id_flush_c;
  logic id_ex_flush_c;
  logic freeze_c;
  logic flush_inc;
  logic stall_inc;

  assign lu = load_use(id_ex_mem_read, id_ex_rd,
                       if_id_rs1, if_id_rs2,
                       if_id_use_rs1, if_id_use_rs2);

  assign mem_stall = dmem_req && !dmem_ready;

  always_comb begin
    state_n       = state_q;
    rem_n         = rem_q;
    timer_n       = timer_q;
    err_n         = err_q;
    run_flow      = 1'b0;
    pc_write_c    = 1'b1;
    if_id_write_c = 1'b1;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    freeze_c      = 1'b0;
    flush_inc     = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          freeze_c = 1'b1;
          state_n  = MEM_WAIT;
          timer_n  = TMR_ONE;
        end else begin
          run_flow = 1'b1;
        end
      end
      LU_STALL: begin
        if (mem_stall) begin
          freeze_c = 1'b1;
          state_n  = MEM_WAIT;
          timer_n  = TMR_ONE;
        end else begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          id_ex_flush_c = 1'b1;
          rem_n         = rem_q - 1'b1;
          if (rem_n == '0) state_n = RUN;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          // The ready cycle advances the pipe: finish any pending bubble,
          // otherwise behave as a fresh RUN cycle (held redirect applies).
          timer_n = '0;
          if (rem_q != '0) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            id_ex_flush_c = 1'b1;
            rem_n         = rem_q - 1'b1;
            state_n       = (rem_n != '0) ? LU_STALL : RUN;
          end else begin
            state_n  = RUN;
            run_flow = 1'b1;
          end
        end else if (timer_q == TMR_MAX) begin
          freeze_c = 1'b1;
          state_n  = ERROR;
          err_n    = 1'b1;
        end else begin
          freeze_c = 1'b1;
          timer_n  = timer_q + 1'b1;
        end
      end
      ERROR: begin
        freeze_c = 1'b1;
      end
    endcase

    if (run_flow) begin
      if (ex_redirect) begin
        if_id_flush_c = 1'b1;
        id_ex_flush_c = 1'b1;
        flush_inc     = 1'b1;
      end else if (lu) begin
        pc_write_c    = 1'b0;
        if_id_write_c = 1'b0;
        id_ex_flush_c = 1'b1;
        if (LOAD_USE_STALL > 1) begin
          state_n = LU_STALL;
          rem_n   = LU_EXTRA;
        end
      end
    end

    if (freeze_c) begin
      pc_write_c    = 1'b0;
      if_id_write_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      rem_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      rem_q   <= rem_n;
      timer_q <= timer_n;
      err_q   <= err_n;
    end
  end

  // Outputs are forced to their idle values for as long as reset is held.
  assign pc_write    = !rst_n || pc_write_c;
  assign if_id_write = !rst_n || if_id_write_c;
  assign if_id_flush = rst_n && if_id_flush_c;
  assign id_ex_flush = rst_n && id_ex_flush_c;
  assign pipe_freeze = rst_n && freeze_c;
  assign bus_error   = err_q;

  assign stall_inc = !pc_write;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc && rst_n),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: default instance (a) and a LOAD_USE_STALL=2,
// WAIT_TIMEOUT=4, 4-bit counter instance (b) on shared inputs.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] if_id_rs1;
  logic [4:0] if_id_rs2;
  logic       if_id_use_rs1;
  logic       if_id_use_rs2;
  logic [4:0] id_ex_rd;
  logic       id_ex_mem_read;
  logic       ex_redirect;
  logic       dmem_req;
  logic       dmem_ready;

  logic        a_pcw, a_ifw, a_iff, a_idf, a_frz, a_err;
  logic [31:0] a_stall, a_flush;
  logic        b_pcw, b_ifw, b_iff, b_idf, b_frz, b_err;
  logic [3:0]  b_stall, b_flush;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  hazard_control_unit u_a (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .ex_redirect(ex_redirect), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready),
    .pc_write(a_pcw), .if_id_write(a_ifw), .if_id_flush(a_iff),
    .id_ex_flush(a_idf), .pipe_freeze(a_frz), .bus_error(a_err),
    .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  hazard_control_unit #(
    .LOAD_USE_STALL(2), .WAIT_TIMEOUT(4), .CNT_W(4)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .ex_redirect(ex_redirect), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready),
    .pc_write(b_pcw), .if_id_write(b_ifw), .if_id_flush(b_iff),
    .id_ex_flush(b_idf), .pipe_freeze(b_frz), .bus_error(b_err),
    .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  // {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze}
  wire [4:0] ctl_a = {a_pcw, a_ifw, a_iff, a_idf, a_frz};
  wire [4:0] ctl_b = {b_pcw, b_ifw, b_iff, b_idf, b_frz};

  localparam logic [4:0] IDLE   = 5'b11000;
  localparam logic [4:0] BUBBLE = 5'b00010;
  localparam logic [4:0] SQUASH = 5'b11110;
  localparam logic [4:0] FROZEN = 5'b00001;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    if_id_rs1      = 5'd0;
    if_id_rs2      = 5'd0;
    if_id_use_rs1  = 1'b0;
    if_id_use_rs2  = 1'b0;
    id_ex_rd       = 5'd0;
    id_ex_mem_read = 1'b0;
    ex_redirect    = 1'b0;
    dmem_req       = 1'b0;
    dmem_ready     = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1,
                        input logic u1, input logic [4:0] rs2,
                        input logic u2);
    id_ex_mem_read = 1'b1;
    id_ex_rd       = rd;
    if_id_rs1      = rs1;
    if_id_use_rs1  = u1;
    if_id_rs2      = rs2;
    if_id_use_rs2  = u2;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    idle_in();
    rst_n = 1'b0;
    set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl_a", 32'(ctl_a), 32'(IDLE));
    chk("rst_ctl_b", 32'(ctl_b), 32'(IDLE));
    chk("rst_stall_a", a_stall, 32'd0);
    chk("rst_flush_a", a_flush, 32'd0);
    chk("rst_err_a", 32'(a_err), 32'd0);
    idle_in();
    rst_n = 1'b1;
    cyc();
    chk("run_idle_a", 32'(ctl_a), 32'(IDLE));

    // load-use on rs1: one bubble for a, two for b
    set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    chk("lu_rs1_a", 32'(ctl_a), 32'(BUBBLE));
    chk("lu_rs1_b", 32'(ctl_b), 32'(BUBBLE));
    cyc();
    idle_in();
    #1;
    chk("lu_after_a", 32'(ctl_a), 32'(IDLE));
    chk("lu_stall_a", a_stall, 32'd1);
    chk("lu2_second_b", 32'(ctl_b), 32'(BUBBLE));
    cyc();
    chk("lu2_done_b", 32'(ctl_b), 32'(IDLE));
    chk("lu2_stall_b", 32'(b_stall), 32'd2);

    // rd=x0 and an unused rs2 match never stall
    pulse_reset();
    set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    chk("lu_x0_a", 32'(ctl_a), 32'(IDLE));
    cyc();
    set_lu(5'd5, 5'd3, 1'b1, 5'd5, 1'b0);
    #1;
    chk("lu_rs2_unused_a", 32'(ctl_a), 32'(IDLE));
    cyc();
    chk("no_stall_a", a_stall, 32'd0);
    set_lu(5'd5, 5'd3, 1'b1, 5'd5, 1'b1);
    #1;
    chk("lu_rs2_a", 32'(ctl_a), 32'(BUBBLE));
    id_ex_mem_read = 1'b0;
    #1;
    chk("lu_not_load_a", 32'(ctl_a), 32'(IDLE));
    idle_in();

    // redirect beats load-use
    pulse_reset();
    set_lu(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
    ex_redirect = 1'b1;
    #1;
    chk("redir_lu_a", 32'(ctl_a), 32'(SQUASH));
    cyc();
    idle_in();
    chk("redir_flush_a", a_flush, 32'd1);
    chk("redir_stall_a", a_stall, 32'd0);

    // 3-cycle dmem wait, redirect held until the ready cycle
    pulse_reset();
    dmem_req = 1'b1;
    ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("wait_frz%0d_a", i), 32'(ctl_a), 32'(FROZEN));
      cyc();
    end
    dmem_ready = 1'b1;
    #1;
    chk("wait_ready_a", 32'(ctl_a), 32'(SQUASH));
    cyc();
    idle_in();
    chk("wait_stall_a", a_stall, 32'd3);
    chk("wait_flush_a", a_flush, 32'd1);
    chk("wait_err_b", 32'(b_err), 32'd0);
    #1;
    chk("wait_after_a", 32'(ctl_a), 32'(IDLE));

    // timeout on b (WAIT_TIMEOUT=4), then async reset mid-error
    pulse_reset();
    dmem_req = 1'b1;
    repeat (4) cyc();
    chk("to_pre_err_b", 32'(b_err), 32'd0);
    chk("to_pre_frz_b", 32'(ctl_b), 32'(FROZEN));
    cyc();
    chk("to_err_b", 32'(b_err), 32'd1);
    chk("to_err_frz_b", 32'(ctl_b), 32'(FROZEN));
    chk("to_noerr_a", 32'(a_err), 32'd0);
    repeat (12) cyc();
    chk("to_err_hold_b", 32'(b_err), 32'd1);
    chk("to_sat_b", 32'(b_stall), 32'd15);
    chk("to_stall_a", a_stall, 32'd17);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ctl_b", 32'(ctl_b), 32'(IDLE));
    chk("arst_err_b", 32'(b_err), 32'd0);
    chk("arst_stall_b", 32'(b_stall), 32'd0);
    chk("arst_ctl_a", 32'(ctl_a), 32'(IDLE));
    idle_in();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // b: bubble, 2-cycle wait inside LU_STALL, last bubble, RUN
    set_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    #1;
    chk("luw_bub_b", 32'(ctl_b), 32'(BUBBLE));
    cyc();
    idle_in();
    dmem_req = 1'b1;
    #1;
    chk("luw_frz0_b", 32'(ctl_b), 32'(FROZEN));
    cyc();
    chk("luw_frz1_b", 32'(ctl_b), 32'(FROZEN));
    cyc();
    dmem_ready = 1'b1;
    #1;
    chk("luw_last_b", 32'(ctl_b), 32'(BUBBLE));
    chk("luw_ready_a", 32'(ctl_a), 32'(IDLE));
    cyc();
    idle_in();
    #1;
    chk("luw_run_b", 32'(ctl_b), 32'(IDLE));
    chk("luw_stall_b", 32'(b_stall), 32'd4);
    chk("luw_stall_a", a_stall, 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
